// File: rtl/bpred_pkg.sv
// Shared definitions for the branch predictor: default geometry, counter type
// and the weakly-not-taken counter initial value.
package bpred_pkg;

   localparam int PC_W_DEF  = 16;
   localparam int IDX_W_DEF = 4;
   localparam int CTR_W_DEF = 2;

   typedef logic [CTR_W_DEF-1:0] ctr_t;

   // Weakly not-taken: the largest value whose MSB is still 0.
   function automatic int ctr_init(input int w);
      return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
   endfunction

endpackage

// File: rtl/sat_ctr.sv
// Next-state logic of one saturating up/down counter (no wrap at either end).
module sat_ctr
   import bpred_pkg::*;
#(
   parameter int W = CTR_W_DEF
) (
   input  logic [W-1:0] cur,
   input  logic         up,
   output logic [W-1:0] nxt
);

   // Step toward the requested direction unless already at that rail.
   always_comb begin
      nxt = cur;
      if (up) begin
         if (cur != {W{1'b1}}) begin
            nxt = cur + W'(1'b1);
         end else begin
            nxt = cur;
         end
      end else begin
         if (cur != {W{1'b0}}) begin
            nxt = cur - W'(1'b1);
         end else begin
            nxt = cur;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare branch direction predictor with a one-cycle lookup.
// Optional statistics counters are enabled by defining BPRED_STATS_EN.
module branch_predictor
   import bpred_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter int CTR_W  = CTR_W_DEF,
   parameter int GSHARE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lkp_valid,
   input  logic [PC_W-1:0]  lkp_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   input  logic             upd_mispredict,
`ifdef BPRED_STATS_EN
   output logic [15:0]      stat_branches,
   output logic [15:0]      stat_mispred,
`endif
   input  logic             clear
);

   localparam int               ENTRIES  = 2 ** IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

   logic [CTR_W-1:0] ctr_r [ENTRIES];
   logic [IDX_W-1:0] ghr_s;
   logic [IDX_W-1:0] lkp_idx_s;
   logic [CTR_W-1:0] upd_cur_s;
   logic [CTR_W-1:0] upd_nxt_s;
   logic             pred_valid_r;
   logic             pred_taken_r;
   logic [IDX_W-1:0] pred_idx_r;
   logic             unused_s;

   // Bit 0 of the PC is ignored (half-word aligned instructions).
   assign lkp_idx_s = lkp_pc[IDX_W:1] ^ ghr_s;
   assign upd_cur_s = ctr_r[upd_idx];
   assign unused_s  = ^{lkp_pc[PC_W-1:IDX_W+1], lkp_pc[0], upd_mispredict};

   sat_ctr #(.W(CTR_W)) u_upd_ctr (
      .cur (upd_cur_s),
      .up  (upd_taken),
      .nxt (upd_nxt_s)
   );

   if (GSHARE != 0) begin : g_ghr
      logic [IDX_W-1:0] ghr_r;

      // Global history, updated only with resolved outcomes.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            ghr_r <= {IDX_W{1'b0}};
         end else if (clear) begin
            ghr_r <= {IDX_W{1'b0}};
         end else if (upd_valid) begin
            ghr_r <= IDX_W'({ghr_r, upd_taken});
         end
      end

      assign ghr_s = ghr_r;
   end else begin : g_no_ghr
      assign ghr_s = {IDX_W{1'b0}};
   end

   // Counter table; the lookup reads the pre-update value of this same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_r[i] <= CTR_INIT;
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) ctr_r[i] <= CTR_INIT;
      end else if (upd_valid) begin
         ctr_r[upd_idx] <= upd_nxt_s;
      end
   end

   // Registered prediction outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred_valid_r <= 1'b0;
         pred_taken_r <= 1'b0;
         pred_idx_r   <= {IDX_W{1'b0}};
      end else if (clear) begin
         pred_valid_r <= 1'b0;
         pred_taken_r <= 1'b0;
         pred_idx_r   <= {IDX_W{1'b0}};
      end else begin
         pred_valid_r <= lkp_valid;
         if (lkp_valid) begin
            pred_taken_r <= ctr_r[lkp_idx_s][CTR_W-1];
            pred_idx_r   <= lkp_idx_s;
         end
      end
   end

   assign pred_valid = pred_valid_r;
   assign pred_taken = pred_taken_r;
   assign pred_idx   = pred_idx_r;

`ifdef BPRED_STATS_EN
   logic [15:0] stat_branches_r;
   logic [15:0] stat_mispred_r;

   // Saturating resolved-branch and mispredict counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches_r <= 16'h0000;
         stat_mispred_r  <= 16'h0000;
      end else if (clear) begin
         stat_branches_r <= 16'h0000;
         stat_mispred_r  <= 16'h0000;
      end else if (upd_valid) begin
         if (stat_branches_r != 16'hFFFF) stat_branches_r <= stat_branches_r + 16'h0001;
         if (upd_mispredict && (stat_mispred_r != 16'hFFFF)) begin
            stat_mispred_r <= stat_mispred_r + 16'h0001;
         end
      end
   end

   assign stat_branches = stat_branches_r;
   assign stat_mispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal and a gshare instance share
// stimulus; expected predictions are queued at lookup and checked one edge later.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        lkp_valid = 1'b0;
   logic [15:0] lkp_pc = 16'h0000;
   logic        upd_valid = 1'b0;
   logic [3:0]  upd_idx = 4'h0;
   logic        upd_taken = 1'b0;
   logic        upd_mispredict = 1'b0;
   logic        clear = 1'b0;

   logic        pv0, pt0, pv1, pt1;
   logic [3:0]  pi0, pi1;
`ifdef BPRED_STATS_EN
   logic [15:0] sb0, sm0, sb1, sm1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string      tag;
      logic       valid;
      logic       taken;
      logic [3:0] idx0;
      logic       chk1;
      logic       taken1;
      logic [3:0] idx1;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   branch_predictor #(.GSHARE(0)) dut0 (
      .clk(clk), .rst(rst), .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
      .pred_valid(pv0), .pred_taken(pt0), .pred_idx(pi0),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict),
`ifdef BPRED_STATS_EN
      .stat_branches(sb0), .stat_mispred(sm0),
`endif
      .clear(clear)
   );

   branch_predictor #(.GSHARE(1)) dut1 (
      .clk(clk), .rst(rst), .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
      .pred_valid(pv1), .pred_taken(pt1), .pred_idx(pi1),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict),
`ifdef BPRED_STATS_EN
      .stat_branches(sb1), .stat_mispred(sm1),
`endif
      .clear(clear)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lkp(input string tag, input logic [15:0] pc, input logic et,
                      input logic [3:0] ei0, input logic c1, input logic et1,
                      input logic [3:0] ei1);
      exp_t e;
      lkp_valid = 1'b1;
      lkp_pc    = pc;
      e.tag = tag; e.valid = 1'b1; e.taken = et; e.idx0 = ei0;
      e.chk1 = c1; e.taken1 = et1; e.idx1 = ei1;
      sb_q.push_back(e);
   endtask

   task automatic upd(input logic [3:0] idx, input logic tk, input logic mp);
      upd_valid      = 1'b1;
      upd_idx        = idx;
      upd_taken      = tk;
      upd_mispredict = mp;
   endtask

   // Advance one edge, check any queued expectation, then idle inputs on negedge.
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, "_valid"}, 16'(pv0), 16'(e.valid));
         if (e.valid) begin
            chk({e.tag, "_taken"}, 16'(pt0), 16'(e.taken));
            chk({e.tag, "_idx"}, 16'(pi0), 16'(e.idx0));
         end
         if (e.chk1) begin
            chk({e.tag, "_g_taken"}, 16'(pt1), 16'(e.taken1));
            chk({e.tag, "_g_idx"}, 16'(pi1), 16'(e.idx1));
         end
      end else begin
         chk("idle_valid", 16'(pv0), 16'h0000);
      end
      @(negedge clk);
      lkp_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; clear = 1'b0;
   endtask

   initial begin
      exp_t e;
      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_valid", 16'(pv0), 16'h0000);
      chk("rst_taken", 16'(pt0), 16'h0000);
      chk("rst_idx", 16'(pi0), 16'h0000);
      chk("rst_g_valid", 16'(pv1), 16'h0000);
      rst = 1'b1;

      // First lookup: weakly not-taken, index from pc[4:1].
      lkp("first", 16'h0004, 1'b0, 4'h2, 1'b1, 1'b0, 4'h2);
      cycle();
      cycle();

      // Training and saturation at the top.
      upd(4'h2, 1'b1, 1'b0); cycle();
      upd(4'h2, 1'b1, 1'b0); cycle();
      lkp("ctr3", 16'h0004, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0); cycle();
      upd(4'h2, 1'b1, 1'b0); cycle();
      lkp("sat_hi", 16'h0004, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0); cycle();
      upd(4'h2, 1'b0, 1'b1); cycle();
      lkp("ctr2", 16'h0004, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0); cycle();

      // Saturation at zero.
      repeat (3) begin upd(4'h2, 1'b0, 1'b0); cycle(); end
      lkp("sat_lo", 16'h0004, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0); cycle();
      upd(4'h2, 1'b1, 1'b0); cycle();

      // Same-cycle update and lookup sees the old value.
      upd(4'h2, 1'b1, 1'b0);
      lkp("no_bypass", 16'h0004, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0); cycle();
      lkp("after_upd", 16'h0004, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0); cycle();

      // Clear beats a simultaneous update and lookup.
      upd(4'h2, 1'b1, 1'b0);
      lkp_valid = 1'b1; lkp_pc = 16'h0004; clear = 1'b1;
      e.tag = "clear"; e.valid = 1'b0; e.taken = 1'b0; e.idx0 = 4'h0;
      e.chk1 = 1'b0; e.taken1 = 1'b0; e.idx1 = 4'h0;
      sb_q.push_back(e);
      cycle();
`ifdef BPRED_STATS_EN
      chk("clear_stat_br", sb0, 16'h0000);
`endif
      for (int i = 0; i < 16; i++) begin
         lkp("post_clear", 16'(i << 1), 1'b0, 4'(i), 1'b0, 1'b0, 4'h0);
         cycle();
      end

      // Gshare history T,T,N -> 4'b0110.
      upd(4'h5, 1'b1, 1'b0); cycle();
      upd(4'h5, 1'b1, 1'b0); cycle();
      upd(4'h5, 1'b0, 1'b0); cycle();
      lkp("gshare", 16'h0004, 1'b0, 4'h2, 1'b1, 1'b0, 4'h4); cycle();
      lkp("gshare2", 16'h000C, 1'b0, 4'h6, 1'b1, 1'b0, 4'h0); cycle();
`ifdef BPRED_STATS_EN
      chk("stat_br3", sb0, 16'h0003);
      chk("stat_mp0", sm0, 16'h0000);
`endif

      // Reset mid-operation discards the in-flight prediction.
      lkp("pre_rst", 16'h0004, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      chk({e.tag, "_valid"}, 16'(pv0), 16'(e.valid));
      lkp_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_valid", 16'(pv0), 16'h0000);
      chk("midrst_idx", 16'(pi0), 16'h0000);
      chk("midrst_g_idx", 16'(pi1), 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      cycle();

`ifdef BPRED_STATS_EN
      // Saturation of the statistics counters.
      clear = 1'b1; cycle();
      upd(4'h1, 1'b1, 1'b1);
      repeat (65537) @(posedge clk);
      @(negedge clk);
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      chk("stat_br_sat", sb0, 16'hFFFF);
      chk("stat_mp_sat", sm0, 16'hFFFF);
      upd(4'h1, 1'b1, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_stat_br", sb0, 16'h0000);
      chk("rst_stat_mp", sm0, 16'h0000);
      chk("rst_pv", 16'(pv0), 16'h0000);
      @(negedge clk);
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      rst = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_W, default 16: program counter width.
REQ-002 Parameter IDX_W, default 4: table index width; the table has 2^IDX_W entries.
REQ-003 Parameter CTR_W, default 2: width of each saturating counter.
REQ-004 Parameter GSHARE, default 0: 0 selects bimodal indexing, 1 selects gshare indexing.
REQ-005 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port lkp_valid, input, 1: lookup request this cycle.
REQ-008 Port lkp_pc, input, PC_W: PC of the instruction being fetched.
REQ-009 Port pred_valid, output, 1: registered prediction is valid.
REQ-010 Port pred_taken, output, 1: predicted direction (expectedTaken for the pipeline).
REQ-011 Port pred_idx, output, IDX_W: table index used; it travels down the pipe with the instruction.
REQ-012 Port upd_valid, input, 1: a branch resolved this cycle.
REQ-013 Port upd_idx, input, IDX_W: pred_idx returned with the resolved branch.
REQ-014 Port upd_taken, input, 1: actual outcome (actualTaken).
REQ-015 Port upd_mispredict, input, 1: the resolved prediction was wrong.
REQ-016 Port clear, input, 1: synchronous flush of all predictor state.

Function
REQ-017 Index SHALL be lkp_pc[IDX_W:1] XOR ghr when GSHARE=1, and lkp_pc[IDX_W:1] alone when GSHARE=0.
REQ-018 Lookup latency SHALL be one cycle: lkp_valid at edge N drives pred_valid/pred_taken/pred_idx after edge N.
REQ-019 pred_valid SHALL be 0 in any cycle following a cycle with lkp_valid=0.
REQ-020 pred_taken SHALL equal the MSB of the indexed counter.
REQ-021 On upd_valid, counter[upd_idx] SHALL increment when upd_taken=1 and decrement otherwise, saturating at 2^CTR_W-1 and at 0 (no wrap).
REQ-022 On upd_valid, ghr SHALL shift left with upd_taken inserted at bit 0; the update is non-speculative. ghr exists only when GSHARE=1.
REQ-023 A lookup and an update to the same index in the same cycle SHALL read the pre-update counter value (no write-to-read bypass).
REQ-024 clear SHALL, at the next edge, set all counters to CTR_INIT, set ghr to 0, and set pred_valid to 0; clear takes priority over a simultaneous update or lookup.
REQ-025 upd_mispredict SHALL NOT affect counter or ghr behaviour; it feeds only the statistics.

Reset
REQ-026 While rst=0, all counters SHALL be CTR_INIT = 2^(CTR_W-1)-1 (weakly not-taken).
REQ-027 While rst=0, ghr SHALL be 0, pred_valid 0, pred_taken 0, and pred_idx 0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight lookup; the first valid prediction requires lkp_valid after rst returns to 1.

Configuration
REQ-029 With macro BPRED_STATS_EN defined, the block SHALL add 16-bit outputs stat_branches and stat_mispred.
REQ-030 stat_branches SHALL count upd_valid and stat_mispred SHALL count upd_valid&upd_mispredict; both saturate at 16'hFFFF and are zeroed by reset or clear.
REQ-031 Without BPRED_STATS_EN, neither statistics port nor its registers SHALL exist; all other behaviour is identical.

Structure
REQ-032 Shared package bpred_pkg SHALL hold default PC_W, IDX_W, CTR_W, the CTR_INIT computation, and the saturating-counter width type.
REQ-033 Sub-module sat_ctr SHALL implement the next-state logic of one saturating up/down counter; it is instantiated once for the update path.

Verification
REQ-034 Reset release, lkp_valid=1, lkp_pc=16'h0004, GSHARE=0 -> next cycle pred_valid=1, pred_taken=0, pred_idx=4'h2.
REQ-035 Two updates with upd_idx=2 and upd_taken=1, then a lookup at 16'h0004 -> pred_taken=1 (counter 3); a third taken update keeps the counter at 3, and one not-taken update gives pred_taken=1 (counter 2).
REQ-036 Same-cycle update of index 2 (counter 1 to 2) and lookup of index 2 -> pred_taken=0; a lookup in the following cycle gives pred_taken=1.
REQ-037 GSHARE=1 with updates taken, taken, not-taken -> ghr=4'b0110; a lookup at 16'h0004 gives pred_idx=4'h4.
REQ-038 clear asserted together with upd_valid for a trained entry -> every lookup afterwards gives pred_taken=0, and stat_branches=0 when BPRED_STATS_EN is defined.
REQ-039 BPRED_STATS_EN defined, 65537 updates with upd_mispredict=1 -> stat_branches=16'hFFFF and stat_mispred=16'hFFFF; rst pulsed low mid-sequence -> all outputs 0 immediately.
